// File: rtl/uart_sram_bridge_if.sv
// Bundle of UART byte handshakes, SRAM macro pins and status flags for uart_sram_bridge.
// master: the bridge side; slave: the UART/SRAM side.
interface uart_sram_bridge_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_enable;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_enable;
  logic              sram_csb;
  logic              sram_web;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;
  logic              busy;
  logic              cmd_err;

  modport master (
    input  rx_data, rx_valid, tx_ready, sram_dout,
    output rx_ready, rx_enable, tx_data, tx_valid, tx_enable,
           sram_csb, sram_web, sram_addr, sram_din, busy, cmd_err
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, sram_dout,
    input  rx_ready, rx_enable, tx_data, tx_valid, tx_enable,
           sram_csb, sram_web, sram_addr, sram_din, busy, cmd_err
  );
endinterface

// File: rtl/uart_sram_bridge.sv
// Byte-framed read/write command bridge from a UART byte stream to a single-port SRAM.
// Optional inter-byte payload timeout: define SRAM_BRIDGE_TIMEOUT_EN.
module uart_sram_bridge #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  uart_sram_bridge_if.master bus
);
  localparam int NB = DATA_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [7:0] ACK_BYTE = 8'h4B;
  localparam logic [7:0] ERR_BYTE = 8'h45;

  typedef enum logic [2:0] {IDLE, GET_DATA, WR, RD_REQ, RD_CAP, TX} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;          // payload byte index, or tx bytes still to follow
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] din_nx;
  logic [7:0]        tx_data_nx;
  logic              tx_valid_nx, csb_nx, web_nx, cmd_err_nx;
  logic              rx_fire, tx_fire;

  assign rx_fire = bus.rx_valid && bus.rx_ready;
  assign tx_fire = bus.tx_valid && bus.tx_ready;

`ifdef SRAM_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt, to_cnt_nx;
  logic          timeout;

  assign timeout   = (state == GET_DATA) && !rx_fire && (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign to_cnt_nx = ((state == GET_DATA) && !rx_fire) ? to_cnt + 1'b1 : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_cnt <= '0;
    else       to_cnt <= to_cnt_nx;
  end
`else
  logic timeout;
  assign timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case leaves it unassigned (no latches).
    state_nx    = state;
    cnt_nx      = cnt;
    shreg_nx    = shreg;
    addr_nx     = bus.sram_addr;
    din_nx      = bus.sram_din;
    tx_data_nx  = bus.tx_data;
    tx_valid_nx = bus.tx_valid;
    csb_nx      = 1'b1;
    web_nx      = 1'b1;
    cmd_err_nx  = 1'b0;

    unique case (state)
      IDLE: if (rx_fire) begin
        cnt_nx = '0;
        if (bus.rx_data[6:5] != 2'b00) begin
          cmd_err_nx  = 1'b1;
          tx_valid_nx = 1'b1;
          tx_data_nx  = ERR_BYTE;
          state_nx    = TX;
        end else begin
          addr_nx = bus.rx_data[ADDR_W-1:0];
          if (bus.rx_data[7]) begin
            state_nx = GET_DATA;
          end else begin
            csb_nx   = 1'b0;
            state_nx = RD_REQ;
          end
        end
      end
      GET_DATA: begin
        if (rx_fire) begin
          // LSB first: each byte enters at the top and the word shifts down.
          shreg_nx = shreg >> 8;
          shreg_nx[DATA_W-1 -: 8] = bus.rx_data;
          if (cnt == CW'(NB - 1)) begin
            din_nx   = shreg_nx;
            csb_nx   = 1'b0;
            web_nx   = 1'b0;
            cnt_nx   = '0;
            state_nx = WR;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else if (timeout) begin
          cmd_err_nx  = 1'b1;
          tx_valid_nx = 1'b1;
          tx_data_nx  = ERR_BYTE;
          cnt_nx      = '0;
          state_nx    = TX;
        end
      end
      WR: begin
        tx_valid_nx = 1'b1;
        tx_data_nx  = ACK_BYTE;
        cnt_nx      = '0;
        state_nx    = TX;
      end
      RD_REQ: state_nx = RD_CAP;
      RD_CAP: begin
        tx_valid_nx = 1'b1;
        tx_data_nx  = bus.sram_dout[7:0];
        shreg_nx    = bus.sram_dout >> 8;
        cnt_nx      = CW'(NB - 1);
        state_nx    = TX;
      end
      TX: if (tx_fire) begin
        if (cnt == '0) begin
          tx_valid_nx = 1'b0;
          state_nx    = IDLE;
        end else begin
          tx_data_nx = shreg[7:0];
          shreg_nx   = shreg >> 8;
          cnt_nx     = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      shreg         <= '0;
      bus.rx_ready  <= 1'b0;
      bus.rx_enable <= 1'b0;
      bus.tx_enable <= 1'b0;
      bus.tx_valid  <= 1'b0;
      bus.tx_data   <= '0;
      bus.busy      <= 1'b0;
      bus.cmd_err   <= 1'b0;
      bus.sram_csb  <= 1'b1;
      bus.sram_web  <= 1'b1;
      bus.sram_addr <= '0;
      bus.sram_din  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state         <= state_nx;
      cnt           <= cnt_nx;
      shreg         <= shreg_nx;
      bus.rx_ready  <= (state_nx == IDLE) || (state_nx == GET_DATA);
      bus.rx_enable <= 1'b1;
      bus.tx_enable <= 1'b1;
      bus.tx_valid  <= tx_valid_nx;
      bus.tx_data   <= tx_data_nx;
      bus.busy      <= (state_nx != IDLE);
      bus.cmd_err   <= cmd_err_nx;
      bus.sram_csb  <= csb_nx;
      bus.sram_web  <= web_nx;
      bus.sram_addr <= addr_nx;
      bus.sram_din  <= din_nx;
    end
  end
endmodule

// File: tb/tb_uart_sram_bridge.sv
// Directed bench for uart_sram_bridge: write/read, illegal commands, backpressure,
// mid-transaction reset, address boundaries, dropped bytes and (optionally) timeout.
module tb_uart_sram_bridge;
  logic clk;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   wr_cnt = 0;
  int   csb_low_cnt = 0;
  int   err_cnt = 0;
  logic [31:0] mem [32];

  uart_sram_bridge_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  uart_sram_bridge #(.ADDR_W(5), .DATA_W(32), .TIMEOUT_CYC(100)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM macro: one-cycle read latency, write on the enabled edge.
  always @(posedge clk) begin
    if (!bus.sram_csb) begin
      if (!bus.sram_web) mem[bus.sram_addr] <= bus.sram_din;
      else               bus.sram_dout      <= mem[bus.sram_addr];
    end
  end

  always @(posedge clk) begin
    if (!reset && !bus.sram_csb) csb_low_cnt++;
    if (!reset && !bus.sram_csb && !bus.sram_web) wr_cnt++;
    if (!reset && bus.cmd_err) err_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2ms, required to finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge of the cycle after the strobe.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!bus.rx_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.rx_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_byte_ready: rx_ready=%0b after 200 cycles, required 1", bus.rx_ready);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  // Collects n response bytes with tx_ready=1; ok=0 if bytes were not on consecutive cycles.
  task automatic get_resp(input int n, output logic [31:0] w, output logic ok);
    int k = 0;
    w  = '0;
    ok = 1'b1;
    bus.tx_ready = 1'b1;
    while (!bus.tx_valid && k < 200) begin @(negedge clk); k++; end
    if (!bus.tx_valid) begin
      vectors++; miscompares++;
      $display("FAIL get_resp_valid: tx_valid=%0b after 200 cycles, required 1", bus.tx_valid);
    end
    for (int i = 0; i < n; i++) begin
      if (!bus.tx_valid) ok = 1'b0;
      w[8*i +: 8] = bus.tx_data;
      @(negedge clk);
    end
  endtask

  task automatic write_word(input logic [7:0] cmd, input logic [31:0] data);
    logic [31:0] r;
    logic        ok;
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
    get_resp(1, r, ok);
  endtask

  task automatic test_reset;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.rx_ready, bus.rx_enable, bus.tx_enable, bus.tx_valid, bus.busy, bus.cmd_err} !== 6'b0 ||
        bus.tx_data !== 8'h00 || bus.sram_addr !== 5'd0 || bus.sram_din !== 32'h0 ||
        bus.sram_csb !== 1'b1 || bus.sram_web !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values: rdy=%0b rxe=%0b txe=%0b txv=%0b busy=%0b err=%0b txd=%h addr=%0d din=%h csb=%0b web=%0b, required zeros and csb=web=1",
               bus.rx_ready, bus.rx_enable, bus.tx_enable, bus.tx_valid, bus.busy, bus.cmd_err,
               bus.tx_data, bus.sram_addr, bus.sram_din, bus.sram_csb, bus.sram_web);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.rx_enable !== 1'b1 || bus.tx_enable !== 1'b1 || bus.rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL enables_after_reset: rxe=%0b txe=%0b rdy=%0b, required 1 1 1",
               bus.rx_enable, bus.tx_enable, bus.rx_ready);
    end
  endtask

  task automatic test_write_read;
    int          w0;
    logic [31:0] r;
    logic        ok;
    w0 = wr_cnt;
    send_byte(8'h83); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44);
    vectors++;
    if (bus.sram_csb !== 1'b0 || bus.sram_web !== 1'b0 || bus.sram_addr !== 5'd3 || bus.sram_din !== 32'h44332211) begin
      miscompares++;
      $display("FAIL write_cycle: csb=%0b web=%0b addr=%0d din=%h, required 0 0 3 44332211",
               bus.sram_csb, bus.sram_web, bus.sram_addr, bus.sram_din);
    end
    @(negedge clk);
    vectors++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h4B || bus.sram_csb !== 1'b1) begin
      miscompares++;
      $display("FAIL write_ack: txv=%0b txd=%h csb=%0b, required 1 4b 1", bus.tx_valid, bus.tx_data, bus.sram_csb);
    end
    @(negedge clk);
    vectors++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rx_ready !== 1'b1 || wr_cnt - w0 !== 1) begin
      miscompares++;
      $display("FAIL write_done: txv=%0b busy=%0b rdy=%0b writes=%0d, required 0 0 1 1",
               bus.tx_valid, bus.busy, bus.rx_ready, wr_cnt - w0);
    end
    send_byte(8'h03);
    vectors++;
    if (bus.sram_csb !== 1'b0 || bus.sram_web !== 1'b1 || bus.sram_addr !== 5'd3) begin
      miscompares++;
      $display("FAIL read_req: csb=%0b web=%0b addr=%0d, required 0 1 3", bus.sram_csb, bus.sram_web, bus.sram_addr);
    end
    @(negedge clk);
    vectors++;
    if (bus.sram_csb !== 1'b1 || bus.tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL read_cap: csb=%0b txv=%0b, required 1 0", bus.sram_csb, bus.tx_valid);
    end
    @(negedge clk);
    vectors++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h11) begin
      miscompares++;
      $display("FAIL read_first_byte: txv=%0b txd=%h, required 1 11", bus.tx_valid, bus.tx_data);
    end
    get_resp(4, r, ok);
    vectors++;
    if (r !== 32'h44332211 || ok !== 1'b1 || bus.tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL read_bytes: word=%h contiguous=%0b txv_after=%0b, required 44332211 1 0", r, ok, bus.tx_valid);
    end
  endtask

  task automatic test_illegal;
    logic [7:0] bad [3];
    int         e0, c0;
    bad[0] = 8'h40; bad[1] = 8'h20; bad[2] = 8'hE5;
    for (int i = 0; i < 3; i++) begin
      e0 = err_cnt; c0 = csb_low_cnt;
      send_byte(bad[i]);
      vectors++;
      if (bus.cmd_err !== 1'b1 || bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h45) begin
        miscompares++;
        $display("FAIL illegal_%h_resp: err=%0b txv=%0b txd=%h, required 1 1 45", bad[i], bus.cmd_err, bus.tx_valid, bus.tx_data);
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (err_cnt - e0 !== 1 || csb_low_cnt - c0 !== 0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL illegal_%h_side: err_pulses=%0d csb_cycles=%0d busy=%0b, required 1 0 0",
                 bad[i], err_cnt - e0, csb_low_cnt - c0, bus.busy);
      end
    end
  endtask

  task automatic test_backpressure;
    logic stable = 1'b1;
    int   k = 0;
    bus.tx_ready = 1'b0;
    send_byte(8'h03);
    while (!bus.tx_valid && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < 50; i++) begin
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h11) stable = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (stable !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_hold: txv=%0b txd=%h held=%0b, required 1 11 1", bus.tx_valid, bus.tx_data, stable);
    end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_b;
      exp_b = 8'h11 * 8'(i + 1);
      vectors++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_b) begin
        miscompares++;
        $display("FAIL backpressure_byte%0d: txv=%0b txd=%h, required 1 %h", i, bus.tx_valid, bus.tx_data, exp_b);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int          w0;
    logic [31:0] r;
    logic        ok;
    write_word(8'h87, 32'hDEADBEEF);
    w0 = wr_cnt;
    send_byte(8'h87); send_byte(8'h01); send_byte(8'h02);
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.rx_ready !== 1'b0 || bus.tx_valid !== 1'b0 || bus.sram_csb !== 1'b1 ||
        bus.sram_web !== 1'b1 || bus.rx_enable !== 1'b0 || bus.sram_din !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_immediate: busy=%0b rdy=%0b txv=%0b csb=%0b web=%0b rxe=%0b din=%h, required 0 0 0 1 1 0 0",
               bus.busy, bus.rx_ready, bus.tx_valid, bus.sram_csb, bus.sram_web, bus.rx_enable, bus.sram_din);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_byte(8'h07);
    get_resp(4, r, ok);
    vectors++;
    if (r !== 32'hDEADBEEF || ok !== 1'b1 || wr_cnt !== w0) begin
      miscompares++;
      $display("FAIL reset_mid_readback: word=%h contiguous=%0b extra_writes=%0d, required deadbeef 1 0", r, ok, wr_cnt - w0);
    end
  endtask

  task automatic test_boundary_addr;
    logic [31:0] r0, r31;
    logic        ok0, ok31;
    write_word(8'h9F, 32'hA5A55A5A);
    write_word(8'h80, 32'h01234567);
    send_byte(8'h1F); get_resp(4, r31, ok31);
    send_byte(8'h00); get_resp(4, r0, ok0);
    vectors++;
    if (r31 !== 32'hA5A55A5A || r0 !== 32'h01234567 || !ok0 || !ok31 || mem[30] === 32'hA5A55A5A) begin
      miscompares++;
      $display("FAIL boundary_addr: a31=%h a0=%h contiguous=%0b%0b, required a5a55a5a 01234567 11", r31, r0, ok31, ok0);
    end
  endtask

  task automatic test_drop_during_tx;
    logic [31:0] r;
    logic        ok;
    int          e0, k = 0;
    e0 = err_cnt;
    bus.tx_ready = 1'b0;
    send_byte(8'h03);
    while (!bus.tx_valid && k < 20) begin @(negedge clk); k++; end
    vectors++;
    if (bus.rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_rx_ready: rx_ready=%0b during TX, required 0", bus.rx_ready);
    end
    bus.rx_data = 8'h40; bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    get_resp(4, r, ok);
    send_byte(8'h1F);
    get_resp(4, r, ok);
    vectors++;
    if (err_cnt !== e0 || r !== 32'hA5A55A5A || ok !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_next_cmd: err_pulses=%0d word=%h contiguous=%0b, required 0 a5a55a5a 1", err_cnt - e0, r, ok);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    logic        ok;
    write_word(8'h85, 32'hCAFEF00D);
    vectors++;
    if (bus.rx_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ready: rdy=%0b busy=%0b right after ack, required 1 0", bus.rx_ready, bus.busy);
    end
    send_byte(8'h05);
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h0D) begin
      miscompares++;
      $display("FAIL b2b_latency: txv=%0b txd=%h at N+3, required 1 0d", bus.tx_valid, bus.tx_data);
    end
    get_resp(4, r, ok);
    vectors++;
    if (r !== 32'hCAFEF00D || ok !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_data: word=%h contiguous=%0b, required cafef00d 1", r, ok);
    end
  endtask

`ifdef SRAM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout;
    logic [31:0] r;
    logic        ok;
    int          n = 0, w0, e0;
    write_word(8'h81, 32'h13579BDF);
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'h81);
    send_byte(8'hAA);
    n = 1;
    while (!bus.cmd_err && n < 300) begin @(negedge clk); n++; end
    vectors++;
    if (n !== 101 || bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h45) begin
      miscompares++;
      $display("FAIL timeout_abort: err at cycle %0d txv=%0b txd=%h, required 101 1 45", n, bus.tx_valid, bus.tx_data);
    end
    repeat (2) @(negedge clk);
    send_byte(8'h01);
    get_resp(4, r, ok);
    vectors++;
    if (r !== 32'h13579BDF || wr_cnt !== w0 || err_cnt - e0 !== 1) begin
      miscompares++;
      $display("FAIL timeout_nowrite: word=%h writes=%0d errs=%0d, required 13579bdf 0 1", r, wr_cnt - w0, err_cnt - e0);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_write_read();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_boundary_addr();
    test_drop_during_tx();
    test_back_to_back();
`ifdef SRAM_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_sram_bridge.md
# uart_sram_bridge

Byte-level command bridge between the UART receiver/transmitter pair and the single-port 32-bit SRAM macro. It parses framed read/write commands arriving as bytes from the receiver and packs write payloads into SRAM words. It issues single-cycle SRAM accesses and serializes read data and acknowledgements back to the transmitter. It sits between the UART blocks and the SRAM inside the top-level wrapper.

## Interface
- ADDR_W, 5, SRAM word-address width; must be ≤ 5, since the address is carried in the command byte bits [4:0].
- DATA_W, 32, SRAM word width; multiple of 8; NB = DATA_W/8 payload bytes per word.
- TIMEOUT_CYC, 1000000, inter-byte timeout in clk cycles; used only with the timeout macro.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_valid is high.
- rx_valid  in  1  one-cycle strobe for a received byte.
- rx_ready  out  1  bridge can accept a byte.
- rx_enable  out  1  receiver enable.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter can accept a byte.
- tx_enable  out  1  transmitter enable.
- sram_csb  out  1  SRAM chip select, active low.
- sram_web  out  1  SRAM write enable, active low.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_din  out  DATA_W  SRAM write data.
- sram_dout  in  DATA_W  SRAM read data.
- busy  out  1  high in any state other than IDLE.
- cmd_err  out  1  one-cycle pulse when a command is rejected.

## Operation
- Command byte format:
  - bit7 = 1 selects write, 0 selects read.
  - bits[6:5] must be 00; any other value is illegal.
  - bits[ADDR_W-1:0] give the address.
  - Bits between ADDR_W and 4 are ignored.
- Write transaction:
  - Command byte, then NB data bytes, least-significant byte first.
  - The word is written to SRAM.
  - The bridge answers with ack byte 0x4B.
- Read transaction:
  - Command byte only.
  - The bridge reads SRAM and transmits NB bytes, least-significant byte first.
- Illegal command: the bridge pulses cmd_err, transmits 0x45, and returns to IDLE. No SRAM access occurs.
- States:
  - IDLE: wait for a byte; decode it; latch address and direction.
  - GET_DATA: shift in payload bytes using a byte counter (0..NB-1); after byte NB-1, go to WR.
  - WR: sram_csb=0, sram_web=0 for exactly one cycle; then go to TX with 0x4B.
  - RD_REQ: sram_csb=0, sram_web=1 for one cycle.
  - RD_CAP: latch sram_dout into the shift register; go to TX.
  - TX: hold tx_valid=1 and tx_data stable until the cycle where tx_valid && tx_ready. Then shift to the next byte, or return to IDLE after the last byte.
- Outside WR and RD_REQ: sram_csb=1 and sram_web=1.
- rx_ready is 1 only in IDLE and GET_DATA.
- An rx_valid arriving while rx_ready=0 is dropped; the receiver reports the overrun.
- rx_enable and tx_enable are 1 from the first clock after reset deassertion onward.
- Reset values:
  - 0: rx_ready, rx_enable, tx_enable, tx_valid, tx_data, busy, cmd_err, sram_addr, sram_din.
  - 1: sram_csb, sram_web.
  - FSM returns to IDLE and the byte counter clears.
- Reset asserted mid-transaction takes effect immediately. The partial command is discarded and no SRAM write is issued.

## Timing
- All outputs are registered.
- Write path: last data byte strobed in cycle N → WR (SRAM write) in N+1 → tx_valid=1 with 0x4B in N+2.
- Read path: command strobed in cycle N → RD_REQ in N+1 → RD_CAP in N+2 (sram_dout sampled at the end of N+2) → tx_valid=1 with byte0 in N+3.
- Between TX bytes: the byte accepted in cycle M is followed by tx_valid=1 with the next byte in M+1. tx_valid never drops between bytes of one response.
- Back-to-back commands: the first rx_valid accepted is in the cycle after TX completes (IDLE).
- Address 2^ADDR_W-1 and address 0 behave identically; there is no wrap or auto-increment.

## Configuration
- SRAM_BRIDGE_TIMEOUT_EN defined:
  - A counter clears on every accepted byte and runs while in GET_DATA.
  - Reaching TIMEOUT_CYC aborts the transaction: cmd_err pulses, 0x45 is transmitted, the FSM returns to IDLE, and no SRAM write occurs.
- SRAM_BRIDGE_TIMEOUT_EN undefined: GET_DATA waits indefinitely and TIMEOUT_CYC is unused.

## Test plan
- Write then read: send 0x83, 0x11, 0x22, 0x33, 0x44 → single write cycle with sram_addr=3, sram_din=0x44332211; tx emits 0x4B. Then send 0x03 → tx emits 0x11, 0x22, 0x33, 0x44.
- Illegal command 0x40 → cmd_err pulses once; tx emits 0x45; sram_csb stays 1 throughout.
- Backpressure: hold tx_ready=0 for 50 cycles during a read response → tx_valid stays 1 and tx_data stays 0x11. On release, all four bytes are sent in order with no loss.
- Reset after 2 payload bytes of a write to address 7 (prior contents 0xDEADBEEF) → outputs take reset values immediately. A following read of address 7 returns EF, BE, AD, DE.
- With SRAM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYC=100: send 0x81, 0xAA, then idle → at the 100th idle cycle cmd_err pulses and 0x45 is sent. A subsequent read of address 1 returns the unchanged data.
- Byte sent during TX (rx_ready=0) → byte ignored; the next command decodes correctly.
